pf_ddrphy_odt_lane_ctrl: RTL and testbench

Parametrised ODT/output-lane controller for the LPDDR3 PHY block. It generates the per-channel serialised ODT waveform words (TX_DATA/OE_DATA/ODT_EN) that feed NUM_CH output IODs from phase-accurate start/length requests. It also contains one shared delay-line stepping engine that drives the IODs' DELAY_LINE_MOVE/DIRECTION/LOAD pins with range protection. It sits between the DDR controller's ODT timing logic and the IOD_ODT lanes, replacing the fixed single-lane wrapper.

---
 rtl/pf_ddrphy_odt_pkg.sv | 22 ++
 rtl/pf_ddrphy_odt_burst.sv | 81 ++++++++
 rtl/pf_ddrphy_odt_lane_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pf_ddrphy_odt_lane_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pf_ddrphy_odt_pkg.sv
// pf_ddrphy_odt_pkg
// Shared definitions for the ODT lane controller: the delay-engine state
// encoding and the serialisation-ratio helpers used to size phase fields.
package pf_ddrphy_odt_pkg;

    typedef enum logic [2:0] {
        DLY_IDLE,
        DLY_LOAD,
        DLY_MOVE,
        DLY_GAP,
        DLY_DONE
    } dly_state_t;

    localparam int RATIO_MIN = 4;
    localparam int RATIO_MAX = 8;

    // Phase-index width for a given serialisation ratio (never below 1 bit).
    function automatic int ratio_pw(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/pf_ddrphy_odt_burst.sv
// pf_ddrphy_odt_burst
// One ODT lane: turns a (start phase, length) request into serialised
// RATIO-bit words, followed by one postamble word with OE still asserted.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req, phase, len     start request; accepted only while busy is low, len=0 dropped
//   busy                burst (including postamble word) in progress
//   tx_data, oe_data    per-phase ODT bits / output enable, bit 0 earliest
//   odt_en              word contains at least one active phase
module pf_ddrphy_odt_burst
    import pf_ddrphy_odt_pkg::*;
#(
    parameter int RATIO = 4,
    parameter int LEN_W = 6,
    localparam int PW   = ratio_pw(RATIO)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [PW-1:0]    phase,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic [RATIO-1:0] tx_data,
    output logic [RATIO-1:0] oe_data,
    output logic             odt_en
);

    logic [LEN_W-1:0] rem;
    logic [LEN_W-1:0] rem_nxt;
    logic             post;
    logic [RATIO-1:0] word;
    int               s_i;
    int               r_i;
    int               take;

    // The first word is built straight from the request; later words always
    // start at phase 0 with the remaining count.
    always_comb begin
        s_i  = busy ? 0 : int'(phase);
        r_i  = busy ? int'(rem) : int'(len);
        word = '0;
        for (int i = 0; i < RATIO; i++)
            word[i] = (i >= s_i) && (i < s_i + r_i);
        take    = (r_i > RATIO - s_i) ? (RATIO - s_i) : r_i;
        rem_nxt = LEN_W'(r_i - take);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem     <= '0;
            post    <= 1'b0;
            busy    <= 1'b0;
            tx_data <= '0;
            oe_data <= '0;
            odt_en  <= 1'b0;
        end else if (!busy) begin
            if (req && len != '0) begin
                tx_data <= word;
                oe_data <= '1;
                odt_en  <= |word;
                busy    <= 1'b1;
                rem     <= rem_nxt;
                post    <= 1'b0;
            end
        end else if (rem != '0) begin
            tx_data <= word;
            odt_en  <= |word;
            rem     <= rem_nxt;
        end else if (!post) begin
            // postamble word: OE and BUSY stay up, no ODT bits
            tx_data <= '0;
            odt_en  <= 1'b0;
            post    <= 1'b1;
        end else begin
            busy    <= 1'b0;
            oe_data <= '0;
            post    <= 1'b0;
        end
    end

endmodule

// File: rtl/pf_ddrphy_odt_lane_ctrl.sv
// pf_ddrphy_odt_lane_ctrl
// NUM_CH ODT lanes plus one shared IOD delay-line stepping engine.
// Ports:
//   FAB_CLK, TX_SYNC_RST               clock, synchronous active-high reset
//   ODT_REQ/ODT_PHASE/ODT_LEN, BUSY    per-lane burst requests and status
//   TX_DATA/OE_DATA/ODT_EN             per-lane serialised words to the IODs
//   DLY_REQ/DLY_CH/DLY_DIR/DLY_CNT     delay-step command (CNT=0 -> load only)
//   DLY_ACK, DLY_ERR                   completion pulse, sticky range error
//   DELAY_LINE_MOVE/DIRECTION/LOAD     per-lane IOD delay controls
//   DELAY_LINE_OUT_OF_RANGE            per-lane IOD range flag
//   DLY_POS                            tracked tap positions
// Config macro: ODT_DLY_POS_TRACK_EN enables per-lane tap counters that
// block moves past either end of the range; otherwise DLY_POS reads 0.
module pf_ddrphy_odt_lane_ctrl
    import pf_ddrphy_odt_pkg::*;
#(
    parameter int NUM_CH = 1,
    parameter int RATIO  = 4,
    parameter int LEN_W  = 6,
    parameter int POS_W  = 7,
    localparam int PW    = ratio_pw(RATIO),
    localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    FAB_CLK,
    input  logic                    TX_SYNC_RST,
    input  logic [NUM_CH-1:0]       ODT_REQ,
    input  logic [NUM_CH*PW-1:0]    ODT_PHASE,
    input  logic [NUM_CH*LEN_W-1:0] ODT_LEN,
    output logic [NUM_CH-1:0]       BUSY,
    output logic [NUM_CH*RATIO-1:0] TX_DATA,
    output logic [NUM_CH*RATIO-1:0] OE_DATA,
    output logic [NUM_CH-1:0]       ODT_EN,
    input  logic                    DLY_REQ,
    input  logic [CHW-1:0]          DLY_CH,
    input  logic                    DLY_DIR,
    input  logic [POS_W-1:0]        DLY_CNT,
    output logic                    DLY_ACK,
    output logic                    DLY_ERR,
    output logic [NUM_CH-1:0]       DELAY_LINE_MOVE,
    output logic [NUM_CH-1:0]       DELAY_LINE_DIRECTION,
    output logic [NUM_CH-1:0]       DELAY_LINE_LOAD,
    input  logic [NUM_CH-1:0]       DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_CH*POS_W-1:0] DLY_POS
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        pf_ddrphy_odt_burst #(.RATIO(RATIO), .LEN_W(LEN_W)) u_burst (
            .clk     (FAB_CLK),
            .rst     (TX_SYNC_RST),
            .req     (ODT_REQ[c]),
            .phase   (ODT_PHASE[c*PW +: PW]),
            .len     (ODT_LEN[c*LEN_W +: LEN_W]),
            .busy    (BUSY[c]),
            .tx_data (TX_DATA[c*RATIO +: RATIO]),
            .oe_data (OE_DATA[c*RATIO +: RATIO]),
            .odt_en  (ODT_EN[c])
        );
    end

    dly_state_t        state;
    logic [CHW-1:0]    ch;
    logic [POS_W-1:0]  cnt;
    logic [NUM_CH-1:0] ch_oh;
    logic [NUM_CH-1:0] req_oh;
    logic              oor_sel;
    logic              blocked;

    // Out-of-range channel numbers decode to no lane at all.
    always_comb begin
        ch_oh   = '0;
        req_oh  = '0;
        oor_sel = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_oh[c]  = (ch == CHW'(c));
            req_oh[c] = (DLY_CH == CHW'(c));
            if (ch_oh[c]) oor_sel = DELAY_LINE_OUT_OF_RANGE[c];
        end
    end

`ifdef ODT_DLY_POS_TRACK_EN
    logic [NUM_CH-1:0][POS_W-1:0] pos_q;
    logic [POS_W-1:0]             pos_sel;
    logic                         dir_cur;

    // Direction is recovered from the held DIRECTION output of the lane.
    always_comb begin
        pos_sel = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (ch_oh[c]) pos_sel = pos_q[c];
        dir_cur = |(DELAY_LINE_DIRECTION & ch_oh);
        blocked = dir_cur ? (pos_sel == '1) : (pos_sel == '0);
    end

    always_ff @(posedge FAB_CLK) begin
        if (TX_SYNC_RST) begin
            pos_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_oh[c] && state == DLY_LOAD)
                    pos_q[c] <= '0;
                else if (ch_oh[c] && state == DLY_MOVE && !blocked)
                    pos_q[c] <= dir_cur ? pos_q[c] + 1'b1 : pos_q[c] - 1'b1;
            end
        end
    end

    assign DLY_POS = pos_q;
`else
    assign blocked = 1'b0;
    assign DLY_POS = '0;
`endif

    // Outputs are registered from the state, so each action shows one cycle
    // after the state that issues it.
    always_ff @(posedge FAB_CLK) begin
        if (TX_SYNC_RST) begin
            state                <= DLY_IDLE;
            ch                   <= '0;
            cnt                  <= '0;
            DLY_ACK              <= 1'b0;
            DLY_ERR              <= 1'b0;
            DELAY_LINE_MOVE      <= '0;
            DELAY_LINE_LOAD      <= '0;
            DELAY_LINE_DIRECTION <= '0;
        end else begin
            DLY_ACK         <= 1'b0;
            DELAY_LINE_MOVE <= '0;
            DELAY_LINE_LOAD <= '0;
            case (state)
                DLY_IDLE: if (DLY_REQ) begin
                    ch      <= DLY_CH;
                    cnt     <= DLY_CNT;
                    DLY_ERR <= 1'b0;
                    if (DLY_CNT == '0) begin
                        state <= DLY_LOAD;
                    end else begin
                        state                <= DLY_MOVE;
                        DELAY_LINE_DIRECTION <= DLY_DIR ? req_oh : '0;
                    end
                end
                DLY_LOAD: begin
                    DELAY_LINE_LOAD <= ch_oh;
                    state           <= DLY_DONE;
                end
                DLY_MOVE: begin
                    if (blocked) begin
                        DLY_ERR <= 1'b1;
                        state   <= DLY_DONE;
                    end else begin
                        DELAY_LINE_MOVE <= ch_oh;
                        cnt             <= cnt - 1'b1;
                        state           <= DLY_GAP;
                    end
                end
                DLY_GAP: begin
                    if (oor_sel) begin
                        DLY_ERR <= 1'b1;
                        state   <= DLY_DONE;
                    end else if (cnt == '0) begin
                        state <= DLY_DONE;
                    end else begin
                        state <= DLY_MOVE;
                    end
                end
                DLY_DONE: begin
                    DLY_ACK              <= 1'b1;
                    DELAY_LINE_DIRECTION <= '0;
                    state                <= DLY_IDLE;
                end
                default: state <= DLY_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pf_ddrphy_odt_lane_ctrl.sv
// Bench for pf_ddrphy_odt_lane_ctrl (2 lanes, RATIO=4). A phase-arithmetic
// reference model predicts every output each cycle; directed scenarios
// follow the spec test plan, then randomized traffic with occasional resets.
module tb_pf_ddrphy_odt_lane_ctrl;
    localparam int NL   = 2;
    localparam int R    = 4;
    localparam int LW   = 6;
    localparam int PWW  = 7;
    localparam int PW   = 2;
    localparam int PHW  = NL * PW;
    localparam int MAXP = 127;
`ifdef ODT_DLY_POS_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NL-1:0]     odt_req = '0;
    logic [PHW-1:0]    odt_phase = '0;
    logic [NL*LW-1:0]  odt_len = '0;
    logic [NL-1:0]     busy;
    logic [NL*R-1:0]   tx_data, oe_data;
    logic [NL-1:0]     odt_en;
    logic              dly_req = 1'b0;
    logic              dly_ch = 1'b0;
    logic              dly_dir = 1'b0;
    logic [PWW-1:0]    dly_cnt = '0;
    logic              dly_ack, dly_err;
    logic [NL-1:0]     dl_move, dl_dir, dl_load;
    logic [NL-1:0]     oor = '0;
    logic [NL*PWW-1:0] dly_pos;

    always #5 clk = ~clk;

    pf_ddrphy_odt_lane_ctrl #(.NUM_CH(NL), .RATIO(R), .LEN_W(LW), .POS_W(PWW)) dut (
        .FAB_CLK(clk), .TX_SYNC_RST(rst),
        .ODT_REQ(odt_req), .ODT_PHASE(odt_phase), .ODT_LEN(odt_len),
        .BUSY(busy), .TX_DATA(tx_data), .OE_DATA(oe_data), .ODT_EN(odt_en),
        .DLY_REQ(dly_req), .DLY_CH(dly_ch), .DLY_DIR(dly_dir), .DLY_CNT(dly_cnt),
        .DLY_ACK(dly_ack), .DLY_ERR(dly_err),
        .DELAY_LINE_MOVE(dl_move), .DELAY_LINE_DIRECTION(dl_dir),
        .DELAY_LINE_LOAD(dl_load), .DELAY_LINE_OUT_OF_RANGE(oor),
        .DLY_POS(dly_pos)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc_n = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_n, got, exp);
    endtask

    // burst model: word k covers absolute phases k*R .. k*R+R-1
    int m_act[NL], m_s[NL], m_l[NL], m_k[NL], m_nw[NL];
    // delay model: dm_t = cycles since the request cycle
    bit dm_act, dm_dir, m_err;
    int dm_t, dm_k, dm_j, dm_ch, dm_ack_at;
    int m_pos[NL];

    logic [NL-1:0]     e_busy, e_en, e_move, e_load, e_dir;
    logic [NL*R-1:0]   e_tx, e_oe;
    logic [NL*PWW-1:0] e_pos;
    logic              e_ack;

    task automatic model_step();
        int ab;
        e_move = '0; e_load = '0; e_ack = 1'b0;
        if (rst) begin
            for (int l = 0; l < NL; l++) begin m_act[l] = 0; m_pos[l] = 0; end
            dm_act = 1'b0; m_err = 1'b0;
        end else begin
            for (int l = 0; l < NL; l++) begin
                if (m_act[l] != 0) begin
                    m_k[l]++;
                    if (m_k[l] == m_nw[l]) m_act[l] = 0;
                end else if (odt_req[l] && odt_len[l*LW +: LW] != 0) begin
                    m_act[l] = 1;
                    m_s[l]   = int'(odt_phase[l*PW +: PW]);
                    m_l[l]   = int'(odt_len[l*LW +: LW]);
                    m_k[l]   = 0;
                    m_nw[l]  = (m_s[l] + m_l[l] + R - 1) / R + 1;
                end
            end
            if (!dm_act) begin
                if (dly_req) begin
                    dm_act = 1'b1; dm_t = 1; m_err = 1'b0;
                    dm_ch = int'(dly_ch); dm_dir = dly_dir; dm_k = int'(dly_cnt);
                    dm_j = 0; dm_ack_at = (dm_k == 0) ? 3 : -1;
                end
            end else begin
                dm_t++;
                if (dm_t == dm_ack_at) begin
                    e_ack = 1'b1; dm_act = 1'b0;
                end else if (dm_k == 0) begin
                    if (dm_t == 2) begin e_load[dm_ch] = 1'b1; m_pos[dm_ch] = 0; end
                end else if (dm_ack_at < 0) begin
                    if (dm_t % 2 == 0) begin
                        if (TRACK && (dm_dir ? m_pos[dm_ch] == MAXP : m_pos[dm_ch] == 0)) begin
                            m_err = 1'b1; dm_ack_at = dm_t + 1;
                        end else begin
                            e_move[dm_ch] = 1'b1;
                            m_pos[dm_ch] += dm_dir ? 1 : -1;
                            dm_j = dm_t / 2;
                        end
                    end else if (dm_t >= 3) begin
                        if (oor[dm_ch]) begin m_err = 1'b1; dm_ack_at = dm_t + 1; end
                        else if (dm_j == dm_k) dm_ack_at = dm_t + 1;
                    end
                end
            end
        end
        for (int l = 0; l < NL; l++) begin
            e_busy[l] = (m_act[l] != 0);
            e_oe[l*R +: R] = (m_act[l] != 0) ? '1 : '0;
            e_tx[l*R +: R] = '0;
            if (m_act[l] != 0 && m_k[l] < m_nw[l] - 1)
                for (int i = 0; i < R; i++) begin
                    ab = m_k[l] * R + i;
                    e_tx[l*R + i] = (ab >= m_s[l]) && (ab < m_s[l] + m_l[l]);
                end
            e_en[l] = |e_tx[l*R +: R];
            e_dir[l] = dm_act && dm_k > 0 && dm_dir && dm_ch == l;
            e_pos[l*PWW +: PWW] = TRACK ? PWW'(m_pos[l]) : '0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        cyc_n++;
        chk("busy", 32'(busy), 32'(e_busy));
        chk("tx_data", 32'(tx_data), 32'(e_tx));
        chk("oe_data", 32'(oe_data), 32'(e_oe));
        chk("odt_en", 32'(odt_en), 32'(e_en));
        chk("dl_move", 32'(dl_move), 32'(e_move));
        chk("dl_load", 32'(dl_load), 32'(e_load));
        chk("dl_dir", 32'(dl_dir), 32'(e_dir));
        chk("dly_ack", 32'(dly_ack), 32'(e_ack));
        chk("dly_err", 32'(dly_err), 32'(m_err));
        chk("dly_pos", 32'(dly_pos), 32'(e_pos));
    endtask

    task automatic dly_cmd(input logic c, input logic d, input int k);
        dly_req = 1'b1; dly_ch = c; dly_dir = d; dly_cnt = PWW'(k);
        cyc();
        dly_req = 1'b0;
    endtask

    initial begin
        int np, ackt;
        bit seen;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack_err", {dly_ack, dly_err}, 0);

        // S=1, L=6 on lane 0
        odt_req[0] = 1'b1; odt_phase[1:0] = 2'd1; odt_len[LW-1:0] = 6'd6;
        cyc();
        odt_req[0] = 1'b0;
        chk("tp_w0", 32'(tx_data[3:0]), 32'b1110);
        chk("tp_busy0", 32'(busy[0]), 1);
        // lane 0 busy: this request must be dropped
        odt_req[0] = 1'b1; odt_len[LW-1:0] = 6'd9;
        cyc();
        odt_req[0] = 1'b0;
        chk("tp_w1", 32'(tx_data[3:0]), 32'b0111);
        chk("tp_en1", 32'(odt_en[0]), 1);
        cyc();
        chk("tp_post_tx", 32'(tx_data[3:0]), 0);
        chk("tp_post_oe", 32'(oe_data[3:0]), 32'hf);
        chk("tp_post_busy", 32'(busy[0]), 1);
        cyc();
        chk("tp_idle_busy", 32'(busy[0]), 0);
        chk("tp_idle_oe", 32'(oe_data[3:0]), 0);

        // L=0 request is ignored
        odt_req[1] = 1'b1; odt_len[2*LW-1:LW] = 6'd0;
        cyc();
        odt_req[1] = 1'b0;
        cyc();
        chk("len0_busy", 32'(busy[1]), 0);

        // ch1, increment, 3 steps
        dly_cmd(1'b1, 1'b1, 3);
        np = 0; ackt = 0;
        for (int t = 2; t <= 12; t++) begin
            cyc();
            if (dl_move[1]) np++;
            if (dly_ack && ackt == 0) ackt = t;
        end
        chk("mv3_pulses", np, 3);
        chk("mv3_ack_cyc", ackt, 8);
`ifdef ODT_DLY_POS_TRACK_EN
        chk("mv3_pos1", 32'(dly_pos[2*PWW-1:PWW]), 3);
`endif

        // range flag after the 2nd move of a 5-step command
        dly_cmd(1'b1, 1'b1, 5);
        np = 0; seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            cyc();
            if (dl_move[1]) np++;
            if (np == 2) oor[1] = 1'b1;
            seen = dly_ack;
        end
        oor[1] = 1'b0;
        chk("oor_ack_seen", 32'(seen), 1);
        chk("oor_pulses", np, 2);
        chk("oor_err", 32'(dly_err), 1);
        dly_cmd(1'b1, 1'b0, 0);
        chk("err_cleared", 32'(dly_err), 0);
        repeat (3) cyc();

        // decrement from freshly loaded position
        dly_cmd(1'b1, 1'b0, 1);
        np = 0;
        repeat (4) begin cyc(); if (dl_move[1]) np++; end
`ifdef ODT_DLY_POS_TRACK_EN
        chk("blk_pulses", np, 0);
        chk("blk_err", 32'(dly_err), 1);
`else
        chk("dec_pulses", np, 1);
`endif

        // reset in the middle of a burst and a command
        odt_req[0] = 1'b1; odt_phase[1:0] = 2'd0; odt_len[LW-1:0] = 6'd20;
        dly_cmd(1'b0, 1'b1, 4);
        odt_req[0] = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_tx", 32'(tx_data), 0);
        chk("mid_rst_dly", {dl_move, dl_dir, dly_ack}, 0);
        odt_req[0] = 1'b1; odt_phase[1:0] = 2'd2; odt_len[LW-1:0] = 6'd3;
        cyc();
        odt_req[0] = 1'b0;
        chk("post_rst_w0", 32'(tx_data[3:0]), 32'b1100);
        cyc();
        chk("post_rst_w1", 32'(tx_data[3:0]), 32'b0001);
        repeat (3) cyc();

        // random traffic
        for (int n = 0; n < 500; n++) begin
            for (int l = 0; l < NL; l++) begin
                odt_req[l] = ($urandom_range(0, 2) == 0);
                odt_phase[l*PW +: PW] = PW'($urandom_range(0, R - 1));
                odt_len[l*LW +: LW] = LW'($urandom_range(0, 20));
                oor[l] = ($urandom_range(0, 15) == 0);
            end
            dly_req = ($urandom_range(0, 7) == 0);
            dly_ch  = 1'($urandom_range(0, 1));
            dly_dir = 1'($urandom_range(0, 1));
            dly_cnt = PWW'($urandom_range(0, 4));
            rst     = ($urandom_range(0, 99) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
